seq_divider_2n_by_n: RTL and testbench
======================================

// Module: seq_divider_2n_by_n
// PURPOSE
//   Iterative unsigned restoring divider. It is the inverse companion to the 4b tree multipliers.
//   Takes a 2N-bit dividend (a multiplier product) and an N-bit divisor.
//   Returns a 2N-bit quotient and an N-bit remainder after 2N step cycles, one quotient bit per cycle.
//   Uses a valid/ready handshake on input and output. Sits beside the multiplier arrays in the arithmetic test harness.
// PARAMETERS
//   N      4    divisor width; dividend and quotient are 2N bits wide
//   CNT_W  $clog2(2*N+1)  width of the step counter (derived, not overridable)
// PORTS
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    asynchronous, active-low reset
//   in_valid   in   1    dividend/divisor valid
//   in_ready   out  1    divider can accept; equals (state==IDLE)
//   dividend   in   2N   unsigned dividend, sampled on the accept edge
//   divisor    in   N    unsigned divisor, sampled on the accept edge
//   out_valid  out  1    result valid; equals (state==DONE)
//   out_ready  in   1    consumer accepts result
//   quotient   out  2N   unsigned quotient
//   remainder  out  N    unsigned remainder, always < divisor when divisor != 0
//   div_zero   out  1    divisor was 0 for the current result
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, counter=0.
//     quotient, remainder and div_zero reset to 0; in_ready=1; out_valid=0.
//   FSM: IDLE -> BUSY on accept (in_valid & in_ready) when divisor != 0.
//        IDLE -> DONE on accept when divisor == 0.
//        BUSY -> DONE on the edge that completes step 2N.
//        DONE -> IDLE on out_ready.
//   Accept edge (divisor != 0):
//     - latch divisor into D;
//     - load shift register Q = dividend;
//     - clear the partial remainder R (N+1 bits);
//     - set counter = 2N.
//   BUSY step, one per edge:
//     - T = {R[N-1:0], Q[2N-1]};
//     - Q <<= 1;
//     - if T >= {1'b0,D}: R = T - D and Q[0] = 1; else R = T and Q[0] = 0;
//     - counter--;
//     - on the edge where counter goes 1 -> 0, the state becomes DONE.
//   Latency: accept at edge k gives out_valid=1 after edge k+2N.
//     With N=4 that is 8 cycles. Throughput is one op per 2N+2 cycles minimum.
//   Divide by zero: the accept edge goes straight to DONE.
//     Result: quotient = all ones, remainder = dividend[N-1:0], div_zero = 1.
//   DONE holds quotient, remainder and div_zero stable until the out_ready edge.
//     div_zero clears on the next accept.
//   out_ready while not DONE is ignored.
//   in_valid while not IDLE is ignored; no input is queued.
//   Accept and result handoff never happen in the same cycle, since in_ready=0 in DONE.
//   Input changes during BUSY have no effect on the result.
//   rst_n low mid-BUSY or mid-DONE aborts immediately. The partial result is discarded and no out_valid pulse occurs.
//   Width rule: R is N+1 bits so T >= D compares without overflow.
//     Subtraction is done at N+1 bits; the remainder output is R[N-1:0].
// STRUCTURE
//   Shared package (arith_pkg):
//     - div_state_t enum {IDLE, BUSY, DONE};
//     - default width N_DEFAULT=4.
//   One sub-module, div_step: purely combinational restoring step.
//     Inputs: (R, q_msb, D). Outputs: (R_next, q_bit).
//     It is instantiated once in the top block; the FSM, counter and registers live in the top block.
// TESTING
//   N=4 throughout; outputs are checked at the out_valid rise.
//   1. 0x9C / 0x7 -> quotient=0x16, remainder=0x2, div_zero=0; out_valid rises exactly 8 cycles after accept.
//   2. Multiplier inverse: 0x8F (13*11) / 0xB -> quotient=0x0D, remainder=0x0.
//      Also sweep all 4b x,y with y != 0: (x*y)/y == x, remainder 0.
//   3. Edge cases:
//      - 0xFF / 0x1 -> quotient=0xFF, remainder=0;
//      - 0x05 / 0xA -> quotient=0x00, remainder=0x5;
//      - 0xFF / 0xF -> quotient=0x11, remainder=0x0.
//   4. 0x3C / 0x0 -> out_valid one cycle after accept, quotient=0xFF, remainder=0xC, div_zero=1.
//      The next valid op clears div_zero.
//   5. Backpressure:
//      - hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0, a new in_valid is ignored;
//      - out_ready=1 -> IDLE next cycle, in_ready=1.
//   6. Assert rst_n low at step 3 of 0x9C/0x7:
//      - all outputs go to reset values immediately, without waiting for clk;
//      - after release, a fresh 0x10/0x3 returns quotient=0x05, remainder=0x1.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-harness definitions: default operand width and divider FSM states.
package arith_pkg;

   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// then subtract the divisor if it fits.
module div_step
   import arith_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic [N:0]   r,
   input  logic         q_msb,
   input  logic [N-1:0] d,
   output logic [N:0]   r_next,
   output logic         q_bit
);

   logic [N:0] t;
   logic       r_msb_unused;

   // A restored remainder is always below the divisor, so its top bit is never set.
   assign r_msb_unused = r[N];

   always_comb begin
      t      = {r[N-1:0], q_msb};
      r_next = t;
      q_bit  = 1'b0;
      if (t >= {1'b0, d}) begin
         r_next = t - {1'b0, d};
         q_bit  = 1'b1;
      end
   end

endmodule

// File: rtl/seq_divider_2n_by_n.sv
// Iterative unsigned restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit
// per clock, with valid/ready handshakes on both sides.
module seq_divider_2n_by_n
   import arith_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] quotient,
   output logic [N-1:0]   remainder,
   output logic           div_zero
);

   localparam int CNT_W = $clog2(2*N+1);

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     d_q, d_d;
   logic [2*N-1:0]   q_q, q_d;
   logic [N:0]       r_q, r_d;
   logic             dz_q, dz_d;
   logic [N:0]       r_step;
   logic             q_bit;

   div_step #(.N(N)) u_step (
      .r      (r_q),
      .q_msb  (q_q[2*N-1]),
      .d      (d_q),
      .r_next (r_step),
      .q_bit  (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         d_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
      end
   end

   // Q doubles as the dividend shifter and the quotient collector.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (divisor == '0) begin
                  state_d = DONE;
                  q_d     = '1;
                  r_d     = {1'b0, dividend[N-1:0]};
                  dz_d    = 1'b1;
               end else begin
                  state_d = BUSY;
                  d_d     = divisor;
                  q_d     = dividend;
                  r_d     = '0;
                  dz_d    = 1'b0;
                  cnt_d   = CNT_W'(2*N);
               end
            end
         end
         BUSY: begin
            q_d   = {q_q[2*N-2:0], q_bit};
            r_d   = r_step;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = q_q;
   assign remainder = r_q[N-1:0];
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divider_2n_by_n.sv
// Scoreboard bench for seq_divider_2n_by_n at N=4: expected results come from a behavioural
// divide model and are compared when out_valid is seen.
module tb_seq_divider_2n_by_n;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_zero;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
      logic [7:0] lat;
   } exp_t;

   exp_t sb[$];
   int   assert_count = 0;
   int   fail_count = 0;
   int   cyc = 0;
   int   accept_cyc = 0;

   seq_divider_2n_by_n #(.N(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one operation, push its expected result, and leave junk on the inputs afterwards.
   task automatic applyStimulus(input logic [7:0] dvd, input logic [3:0] dvs);
      exp_t       e;
      logic [7:0] rem;
      int         n;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      if (dvs == 4'd0) begin
         e.q   = 8'hFF;
         e.r   = dvd[3:0];
         e.dz  = 1'b1;
         e.lat = 8'd0;
      end else begin
         rem   = dvd % {4'd0, dvs};
         e.q   = dvd / {4'd0, dvs};
         e.r   = rem[3:0];
         e.dz  = 1'b0;
         e.lat = 8'd8;
      end
      sb.push_back(e);
      @(negedge clk);
      accept_cyc = cyc;
      dividend   = 8'($urandom);
      divisor    = 4'($urandom);
   endtask

   // Wait for out_valid, compare against the scoreboard, optionally stall, then hand off.
   task automatic waitResult(input int hold);
      exp_t       e;
      logic [7:0] q0;
      logic [3:0] r0;
      int         n;
      n = 0;
      while (!out_valid && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         checkOutput("out_valid_wait", 32'(out_valid), 32'd1);
         in_valid = 1'b0;
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      if (sb.size() == 0) begin
         checkOutput("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      checkOutput("latency", 32'(cyc - accept_cyc), 32'(e.lat));
      checkOutput("quotient", 32'(quotient), 32'(e.q));
      checkOutput("remainder", 32'(remainder), 32'(e.r));
      checkOutput("div_zero", 32'(div_zero), 32'(e.dz));
      q0 = quotient;
      r0 = remainder;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         @(negedge clk);
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_quotient", 32'(quotient), 32'(q0));
         checkOutput("hold_remainder", 32'(remainder), 32'(r0));
         checkOutput("hold_div_zero", 32'(div_zero), 32'(e.dz));
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("handoff_valid", 32'(out_valid), 32'd0);
      checkOutput("handoff_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_quotient", 32'(quotient), 32'd0);
      checkOutput("reset_remainder", 32'(remainder), 32'd0);
      checkOutput("reset_div_zero", 32'(div_zero), 32'd0);
      rst_n = 1'b1;

      applyStimulus(8'h9C, 4'h7);
      waitResult(0);
      applyStimulus(8'h8F, 4'hB);
      waitResult(0);

      applyStimulus(8'hFF, 4'h1);
      waitResult(0);
      applyStimulus(8'h05, 4'hA);
      waitResult(0);
      applyStimulus(8'hFF, 4'hF);
      waitResult(0);

      applyStimulus(8'h3C, 4'h0);
      waitResult(0);
      applyStimulus(8'h9C, 4'h7);
      waitResult(0);

      // out_ready raised while the divider is still busy must not end the operation.
      applyStimulus(8'hC8, 4'h9);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("busy_out_ready_valid", 32'(out_valid), 32'd0);
      checkOutput("busy_out_ready_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b0;
      waitResult(0);

      applyStimulus(8'h9C, 4'h7);
      waitResult(5);
      applyStimulus(8'h3C, 4'h0);
      waitResult(5);

      for (int x = 0; x < 16; x++) begin
         for (int y = 1; y < 16; y++) begin
            applyStimulus(8'(x * y), 4'(y));
            waitResult(0);
         end
      end

      // Asynchronous reset in the middle of a division.
      applyStimulus(8'h9C, 4'h7);
      repeat (2) @(negedge clk);
      checkOutput("abort_busy_valid", 32'(out_valid), 32'd0);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      checkOutput("abort_quotient", 32'(quotient), 32'd0);
      checkOutput("abort_remainder", 32'(remainder), 32'd0);
      checkOutput("abort_div_zero", 32'(div_zero), 32'd0);
      sb.delete();
      repeat (3) @(negedge clk);
      checkOutput("abort_hold_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      applyStimulus(8'h10, 4'h3);
      waitResult(0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
